// File: rtl/mem_responder_pkg.sv
// ============================================================================
//  Module   : mem_responder_pkg
//  Brief    : Shared request/response types and field widths for the cache-to-memory interface.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam int ADDR_FIELD_WIDTH = 32;
    localparam int DATA_FIELD_WIDTH = 64;
    localparam int ACCESS_ID_WIDTH  = 8;
    localparam int CORE_ID_WIDTH    = 4;
    localparam int BYTE_EN_WIDTH    = DATA_FIELD_WIDTH / 8;

    typedef enum logic [2:0] {
        READ_REQ  = 3'd0,
        READ_RSP  = 3'd1,
        WRITE_REQ = 3'd2,
        WRITE_RSP = 3'd3
    } access_type_e;

    typedef struct packed {
        logic                        vld;
        access_type_e                access_type;
        logic [ACCESS_ID_WIDTH-1:0]  access_id;
        logic [CORE_ID_WIDTH-1:0]    core_id;
        logic [ADDR_FIELD_WIDTH-1:0] addr;
        logic [BYTE_EN_WIDTH-1:0]    byte_en;
        logic [DATA_FIELD_WIDTH-1:0] data;
    } request_t;

    function automatic logic [DATA_FIELD_WIDTH-1:0] merge_bytes(
        input logic [DATA_FIELD_WIDTH-1:0] old_word,
        input logic [DATA_FIELD_WIDTH-1:0] new_word,
        input logic [BYTE_EN_WIDTH-1:0]    byte_en
    );
        merge_bytes = old_word;
        for (int b = 0; b < BYTE_EN_WIDTH; b++) begin
            if (byte_en[b]) merge_bytes[8*b +: 8] = new_word[8*b +: 8];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_arb.sv
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Round-robin arbiter; pointer moves past the winner only when told to advance.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    logic [IW-1:0] r_ptr;
    logic          w_found;

    function automatic logic [IW-1:0] wrap_idx(input int v);
        wrap_idx = IW'(v % N);
    endfunction

    always_comb begin
        gnt     = '0;
        index   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[wrap_idx(int'(r_ptr) + i)]) begin
                w_found = 1'b1;
                index   = wrap_idx(int'(r_ptr) + i);
            end
        end
        if (w_found) gnt[index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (index == IW'(N - 1)) ? '0 : index + IW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module   : mem_responder
//  Brief    : Round-robin multi-port responder for a single-port word memory with fixed latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int MEM_DEPTH   = 4096,
    parameter int RD_LATENCY  = 4,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  request_t             mem_req   [NUM_PORTS],
    output logic [NUM_PORTS-1:0] req_grant,
    output request_t             mem_rsp   [NUM_PORTS]
);

    localparam int             c_PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int             c_IDX_W     = $clog2(MEM_DEPTH);
    localparam int             c_QW        = $clog2(QUEUE_DEPTH);
    localparam logic [c_QW:0]  c_FULL      = (c_QW + 1)'(QUEUE_DEPTH);
    localparam logic [7:0]     c_ISSUE_AGE = 8'(RD_LATENCY - 1);

    typedef struct packed {
        logic [c_PW-1:0]             port;
        access_type_e                access_type;
        logic [ACCESS_ID_WIDTH-1:0]  access_id;
        logic [CORE_ID_WIDTH-1:0]    core_id;
        logic [ADDR_FIELD_WIDTH-1:0] addr;
        logic [BYTE_EN_WIDTH-1:0]    byte_en;
        logic [DATA_FIELD_WIDTH-1:0] data;
        logic [7:0]                  ts;
    } mrq_entry_t;

    logic [NUM_PORTS-1:0]        w_req_vld;
    logic [NUM_PORTS-1:0]        w_arb_gnt;
    logic [c_PW-1:0]             w_arb_idx;
    logic                        w_full;
    logic                        w_accept;
    logic                        w_pop;
    logic [7:0]                  w_age;
    logic [c_IDX_W-1:0]          w_idx;
    request_t                    w_sel_req;
    mrq_entry_t                  w_new;
    mrq_entry_t                  w_head;
    request_t                    w_rsp;

    mrq_entry_t                  r_q   [QUEUE_DEPTH];
    logic [DATA_FIELD_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [c_QW-1:0]             r_wr_ptr;
    logic [c_QW-1:0]             r_rd_ptr;
    logic [c_QW:0]               r_occ;
    logic [7:0]                  r_cnt;
    request_t                    r_rsp [NUM_PORTS];

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req_vld),
        .advance (w_accept),
        .gnt     (w_arb_gnt),
        .index   (w_arb_idx)
    );

    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_full    = (r_occ == c_FULL);
    assign req_grant = (reset && !w_full) ? w_arb_gnt : '0;
    assign w_accept  = |req_grant;
    assign w_sel_req = mem_req[w_arb_idx];

    assign w_head = r_q[r_rd_ptr];
    assign w_age  = r_cnt - w_head.ts;
    assign w_pop  = reset && (r_occ != '0) && (w_age == c_ISSUE_AGE);
    assign w_idx  = w_head.addr[c_IDX_W-1:0];

    always_comb begin
        w_new             = '0;
        w_new.port        = w_arb_idx;
        w_new.access_type = w_sel_req.access_type;
        w_new.access_id   = w_sel_req.access_id;
        w_new.core_id     = w_sel_req.core_id;
        w_new.addr        = w_sel_req.addr;
        w_new.byte_en     = w_sel_req.byte_en;
        w_new.data        = w_sel_req.data;
        w_new.ts          = r_cnt;
    end

    always_comb begin
        w_rsp           = '0;
        w_rsp.vld       = 1'b1;
        w_rsp.access_id = w_head.access_id;
        w_rsp.core_id   = w_head.core_id;
        w_rsp.addr      = w_head.addr;
        case (w_head.access_type)
            READ_REQ: begin
                w_rsp.access_type = READ_RSP;
                w_rsp.data        = r_mem[w_idx];
            end
            WRITE_REQ: begin
                w_rsp.access_type = WRITE_RSP;
            end
            default: begin
                w_rsp.access_type = w_head.access_type;
                w_rsp.byte_en     = w_head.byte_en;
                w_rsp.data        = w_head.data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_accept) r_wr_ptr <= r_wr_ptr + c_QW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + c_QW'(1);
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + (c_QW + 1)'(1);
                2'b01:   r_occ <= r_occ - (c_QW + 1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_q[r_wr_ptr] <= w_new;
    end

    always_ff @(posedge clk) begin
        if (w_pop && (w_head.access_type == WRITE_REQ)) begin
            r_mem[w_idx] <= merge_bytes(r_mem[w_idx], w_head.data, w_head.byte_en);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_req_vld[p] = mem_req[p].vld;
        assign mem_rsp[p]   = r_rsp[p];

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_rsp[p] <= '0;
            end else if (w_pop && (w_head.port == c_PW'(p))) begin
                r_rsp[p] <= w_rsp;
            end else begin
                r_rsp[p] <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module   : tb_mem_responder
//  Brief    : Directed self-checking bench for mem_responder (default and shallow-queue builds).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;
    import mem_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    request_t   mem_req     [2];
    logic [1:0] req_grant;
    request_t   mem_rsp     [2];
    request_t   mem_req_b   [2];
    logic [1:0] req_grant_b;
    request_t   mem_rsp_b   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int       cyc;
        int       port;
        request_t r;
    } log_t;

    log_t     acc_log [$];
    log_t     rsp_log [$];
    request_t pend    [2][$];
    logic     acc_flag [2];

    mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .req_grant (req_grant),
        .mem_rsp   (mem_rsp)
    );

    mem_responder #(.QUEUE_DEPTH(2), .RD_LATENCY(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req_b),
        .req_grant (req_grant_b),
        .mem_rsp   (mem_rsp_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            acc_flag[p] = mem_req[p].vld && req_grant[p];
            if (acc_flag[p]) acc_log.push_back('{cyc, p, mem_req[p]});
            if (mem_rsp[p].vld) rsp_log.push_back('{cyc, p, mem_rsp[p]});
        end
    end

    // Each port holds its request until accepted, then presents the next queued one.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acc_flag[p] || !mem_req[p].vld) begin
                if (pend[p].size() > 0) mem_req[p] = pend[p].pop_front();
                else                    mem_req[p] = '0;
            end
        end
    end

    function automatic request_t mk(access_type_e t, int id, logic [31:0] addr,
                                    logic [7:0] be, logic [63:0] d);
        request_t r;
        r             = '0;
        r.vld         = 1'b1;
        r.access_type = t;
        r.access_id   = 8'(id);
        r.core_id     = 4'(id);
        r.addr        = addr;
        r.byte_en     = be;
        r.data        = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        acc_log.delete();
        rsp_log.delete();
    endtask

    task automatic wait_done(input int n_acc, input int n_rsp);
        int n;
        n = 0;
        while ((acc_log.size() < n_acc || rsp_log.size() < n_rsp) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 300) chk("timeout", 64'd0, 64'd1);
        repeat (6) @(negedge clk);
        #1;
    endtask

    initial begin
        int       n;
        int       id;
        int       first;
        int       n_acc_b;
        int       n_rsp_b;
        logic     g;
        logic     b_port1_seen;
        logic [15:0] pat;

        acc_flag[0] = 1'b0;
        acc_flag[1] = 1'b0;
        mem_req[0]   = '0;
        mem_req[1]   = '0;
        mem_req_b[0] = '0;
        mem_req_b[1] = '0;
        reset = 1'b0;

        // Reset: responses cleared, grant suppressed even with a valid request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_req[1] = mk(READ_REQ, 1, 32'h10, 8'h00, 64'd0);
        @(negedge clk);
        chk("rst_grant", 64'(req_grant), 64'd0);
        chk("rst_rsp0", 64'(mem_rsp[0] == '0), 64'd1);
        chk("rst_rsp1", 64'(mem_rsp[1] == '0), 64'd1);
        mem_req[1] = '0;
        @(posedge clk); #2;
        reset = 1'b1;

        // Preload memory through port 1 writes.
        clr();
        for (int i = 0; i < 8; i++)
            pend[1].push_back(mk(WRITE_REQ, 200 + i, 32'h20 + 32'(i), 8'hFF, 64'hC0DE_0000_0000_0020 + 64'(i)));
        pend[1].push_back(mk(WRITE_REQ, 210, 32'h10, 8'hFF, 64'hDEAD_BEEF_0000_0010));
        pend[1].push_back(mk(WRITE_REQ, 211, 32'h5, 8'hFF, 64'd0));
        wait_done(10, 10);
        chk("preload_cnt", 64'(rsp_log.size()), 64'd10);

        // Single read.
        clr();
        pend[0].push_back(mk(READ_REQ, 64, 32'h10, 8'h00, 64'd0));
        wait_done(1, 1);
        chk("t1_cnt", 64'(rsp_log.size()), 64'd1);
        if (rsp_log.size() > 0 && acc_log.size() > 0) begin
            chk("t1_port", 64'(rsp_log[0].port), 64'd0);
            chk("t1_type", 64'(rsp_log[0].r.access_type), 64'(READ_RSP));
            chk("t1_id",   64'(rsp_log[0].r.access_id), 64'd64);
            chk("t1_data", rsp_log[0].r.data, 64'hDEAD_BEEF_0000_0010);
            chk("t1_be",   64'(rsp_log[0].r.byte_en), 64'd0);
            chk("t1_lat",  64'(rsp_log[0].cyc - acc_log[0].cyc), 64'd4);
        end

        // Fill burst of 8 reads on port 0.
        clr();
        for (int i = 0; i < 8; i++)
            pend[0].push_back(mk(READ_REQ, 64 + i, 32'h20 + 32'(i), 8'h00, 64'd0));
        wait_done(8, 8);
        chk("t2_cnt", 64'(rsp_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < rsp_log.size() && i < acc_log.size(); i++) begin
            chk("t2_grant_cyc", 64'(acc_log[i].cyc - acc_log[0].cyc), 64'(i));
            chk("t2_id",   64'(rsp_log[i].r.access_id), 64'(64 + i));
            chk("t2_data", rsp_log[i].r.data, 64'hC0DE_0000_0000_0020 + 64'(i));
            chk("t2_lat",  64'(rsp_log[i].cyc - acc_log[i].cyc), 64'd4);
        end

        // Both ports contending: grants alternate, responses routed back.
        clr();
        for (int i = 0; i < 3; i++) begin
            pend[0].push_back(mk(READ_REQ, 80 + i, 32'h20 + 32'(i), 8'h00, 64'd0));
            pend[1].push_back(mk(READ_REQ, 83 + i, 32'h23 + 32'(i), 8'h00, 64'd0));
        end
        wait_done(6, 6);
        chk("t3_cnt", 64'(rsp_log.size()), 64'd6);
        for (int i = 1; i < 6 && i < acc_log.size(); i++) begin
            chk("t3_alt", 64'(acc_log[i].port), 64'(1 - acc_log[i-1].port));
            chk("t3_gap", 64'(acc_log[i].cyc - acc_log[i-1].cyc), 64'd1);
        end
        for (int i = 0; i < rsp_log.size(); i++) begin
            id = int'(rsp_log[i].r.access_id);
            chk("t3_route", 64'(rsp_log[i].port), (id >= 83) ? 64'd1 : 64'd0);
            chk("t3_data", rsp_log[i].r.data, 64'hC0DE_0000_0000_0020 + 64'(id - 80));
        end

        // Partial write then back-to-back read of the same word.
        clr();
        pend[1].push_back(mk(WRITE_REQ, 90, 32'h5, 8'h0F, 64'h1111_2222_3333_4444));
        pend[1].push_back(mk(READ_REQ, 91, 32'h5, 8'h00, 64'd0));
        wait_done(2, 2);
        chk("t4_cnt", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() >= 2 && acc_log.size() >= 2) begin
            chk("t4_wtype", 64'(rsp_log[0].r.access_type), 64'(WRITE_RSP));
            chk("t4_wdata", rsp_log[0].r.data, 64'd0);
            chk("t4_wid",   64'(rsp_log[0].r.access_id), 64'd90);
            chk("t4_wlat",  64'(rsp_log[0].cyc - acc_log[0].cyc), 64'd4);
            chk("t4_rtype", 64'(rsp_log[1].r.access_type), 64'(READ_RSP));
            chk("t4_rdata", rsp_log[1].r.data, 64'h0000_0000_3333_4444);
            chk("t4_gap",   64'(rsp_log[1].cyc - rsp_log[0].cyc), 64'd1);
            chk("t4_rport", 64'(rsp_log[1].port), 64'd1);
        end

        // Address wrap and an unrecognised access type.
        clr();
        pend[0].push_back(mk(READ_REQ, 93, 32'h0000_1010, 8'h00, 64'd0));
        pend[0].push_back(mk(access_type_e'(3'd6), 94, 32'h7, 8'h5A, 64'h55AA_55AA_0000_1234));
        wait_done(2, 2);
        chk("t4b_cnt", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() >= 2) begin
            chk("t4b_wrap", rsp_log[0].r.data, 64'hDEAD_BEEF_0000_0010);
            chk("t4b_otype", 64'(rsp_log[1].r.access_type), 64'd6);
            chk("t4b_odata", rsp_log[1].r.data, 64'h55AA_55AA_0000_1234);
            chk("t4b_oid",   64'(rsp_log[1].r.access_id), 64'd94);
        end

        // Reset in the middle of a burst drops accepted requests.
        clr();
        for (int i = 0; i < 8; i++)
            pend[0].push_back(mk(READ_REQ, 100 + i, 32'h20 + 32'(i), 8'h00, 64'd0));
        n = 0;
        while (acc_log.size() < 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) chk("t5_timeout", 64'd0, 64'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        pend[0].delete();
        @(negedge clk);
        chk("t5_grant_rst", 64'(req_grant), 64'd0);
        @(posedge clk); #2;
        reset      = 1'b1;
        mem_req[0] = '0;
        repeat (10) @(negedge clk);
        #1;
        chk("t5_acc", 64'(acc_log.size()), 64'd3);
        chk("t5_no_rsp", 64'(rsp_log.size()), 64'd0);

        clr();
        for (int i = 0; i < 8; i++)
            pend[0].push_back(mk(READ_REQ, 108 + i, 32'h20 + 32'(i), 8'h00, 64'd0));
        wait_done(8, 8);
        chk("t5_cnt", 64'(rsp_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < rsp_log.size() && i < acc_log.size(); i++) begin
            chk("t5_id",   64'(rsp_log[i].r.access_id), 64'(108 + i));
            chk("t5_data", rsp_log[i].r.data, 64'hC0DE_0000_0000_0020 + 64'(i));
            chk("t5_lat",  64'(rsp_log[i].cyc - acc_log[i].cyc), 64'd4);
        end

        // Two-entry queue with four-cycle latency: grants come in pairs.
        n_acc_b      = 0;
        n_rsp_b      = 0;
        first        = -1;
        pat          = '0;
        b_port1_seen = 1'b0;
        @(posedge clk); #1;
        mem_req_b[0] = mk(READ_REQ, 0, 32'h40, 8'h00, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rsp_b[1].vld) b_port1_seen = 1'b1;
            if (mem_rsp_b[0].vld) begin
                chk("t6_rsp_id", 64'(mem_rsp_b[0].access_id), 64'(n_rsp_b));
                n_rsp_b++;
            end
            g = req_grant_b[0];
            if (g && first < 0) first = i;
            if (first >= 0 && i - first < 16) pat[i - first] = g;
            @(posedge clk); #1;
            if (g) begin
                n_acc_b++;
                mem_req_b[0] = mk(READ_REQ, n_acc_b, 32'h40 + 32'(n_acc_b), 8'h00, 64'd0);
            end
        end
        mem_req_b[0] = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_rsp_b[1].vld) b_port1_seen = 1'b1;
            if (mem_rsp_b[0].vld) begin
                chk("t6_rsp_id", 64'(mem_rsp_b[0].access_id), 64'(n_rsp_b));
                n_rsp_b++;
            end
        end
        chk("t6_pattern", 64'(pat), 64'h3333);
        chk("t6_count", 64'(n_rsp_b), 64'(n_acc_b));
        chk("t6_port1_idle", 64'(b_port1_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
